chunk_rr_arbiter: RTL and testbench
===================================

CHUNK_RR_ARBITER -- requirements
Module: chunk_rr_arbiter

Interface
REQ-001 Parameter: NUM, default 4, number of requester streams (2..8).
REQ-002 Parameter: DIN_W, default 17, width of each din data word: bit DIN_W-1 = eot, bits DIN_W-2:0 = payload.
REQ-003 Parameter: CFG_W, default 8, width of the chunk-quantum word.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 Port: din[NUM]  dti.consumer  DIN_W  requester streams, each {eot, payload}.
REQ-007 Port: cfg  dti.consumer  CFG_W  chunk quantum Q in beats; Q=0 means unlimited.
REQ-008 Port: dout  dti.producer  $clog2(NUM)+2+DIN_W-1  {sel, eot[1:0], payload}; eot[0]=chunk end, eot[1]=input transaction end.

Function
REQ-009 Two states: IDLE, GRANT; state, grant index sel, rotation pointer ptr, beat counter cnt and quantum register q are registered.
REQ-010 IDLE: dout.valid=0, all din[i].ready=0, cfg.ready=0.
REQ-011 IDLE -> GRANT when cfg.valid=1 and any din[i].valid=1; winner = first valid index scanning ptr, ptr+1, ... modulo NUM.
REQ-012 On that IDLE->GRANT edge: sel<=winner, q<=cfg.data, cnt<=0, and cfg.ready=1 for exactly that cycle (one cfg word per chunk).
REQ-013 No request or cfg.valid=0 in IDLE: stay IDLE, ptr unchanged.
REQ-014 GRANT: dout.valid=din[sel].valid; din[sel].ready=dout.ready; din[i].ready=0 for all i!=sel; cfg.ready=0.
REQ-015 GRANT: dout payload = din[sel] payload, dout.sel = sel, dout.eot[1] = din[sel].eot.
REQ-016 dout.eot[0] = din[sel].eot OR (q!=0 AND cnt==q-1), evaluated combinationally.
REQ-017 Handshake = dout.valid AND dout.ready; cnt increments by 1 per handshake, width CFG_W, never wraps (chunk ends at q-1 first).
REQ-018 With q=0 cnt saturates at all-ones; only din eot ends the chunk.
REQ-019 Handshake with dout.eot[0]=1: next state IDLE, cnt<=0, ptr<=(sel+1) mod NUM.
REQ-020 Chunk ended by quantum (eot[1]=0): requester sel loses grant mid-transaction; its remaining beats are re-arbitrated as a new chunk, keeping beat order per requester.
REQ-021 One idle cycle between consecutive chunks (GRANT->IDLE->GRANT); chunk-to-first-beat latency = 1 cycle after request+cfg valid.
REQ-022 din[sel].valid dropping mid-chunk: hold GRANT, no timeout, no switch.
REQ-023 Simultaneous din eot and cnt==q-1: single chunk end, eot[1:0]=2'b11.
REQ-024 cfg.data changes during GRANT: ignored; q is sampled only at IDLE->GRANT.
REQ-025 No combinational path from dout.ready to dout.valid; din[sel].ready depends on dout.ready only combinationally.

Reset
REQ-026 rst=0 at a clock edge: state<=IDLE, sel<=0, ptr<=0, cnt<=0, q<=0.
REQ-027 During and first cycle after reset: dout.valid=0, all din[i].ready=0, cfg.ready=0.
REQ-028 Reset mid-chunk discards the chunk in progress; no beat is emitted after reset until a new IDLE->GRANT arbitration.

Verification
REQ-029 NUM=4, Q=3, din0 sends 5-beat transaction A0..A4, others idle -> dout: A0,A1,A2(eot=01,sel=0), idle cycle, A3,A4(eot=11,sel=0); two cfg handshakes.
REQ-030 Q=2, din0 and din2 each 4 beats, both valid from reset release -> sel order 0,2,0,2; chunks of 2; last beat of each requester eot=11, others' chunk ends eot=01.
REQ-031 Q=0, din1 8-beat transaction, din3 valid throughout -> all 8 din1 beats contiguous, eot=11 only on beat 8, then sel=3 granted.
REQ-032 Q=4, din0 2-beat transaction -> eot=11 on beat 2 (input eot before quantum), cnt reset, ptr=1.
REQ-033 Random dout.ready (50%) and din valid gaps, Q random 0..5 -> per-requester payload order preserved, no beat lost/duplicated, one cfg handshake per chunk.
REQ-034 rst=0 asserted on beat 2 of a Q=4 chunk -> dout.valid=0 next cycle, ptr=0; after release, arbitration restarts from din0.

Source files
------------

// File: rtl/chunk_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dti (chunk_rr_arbiter_if)
// Description : Valid/ready data-transfer interface used by chunk_rr_arbiter
//               for the requester streams, the quantum word and the output.
// Revision    : 1.0 - initial release
// ============================================================================
interface dti #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  // Producer drives valid/data and observes ready
  modport producer (output valid, output data, input ready);
  // Consumer observes valid/data and drives ready
  modport consumer (input valid, input data, output ready);
  // Aliases for bus-style naming
  modport master   (output valid, output data, input ready);
  modport slave    (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/chunk_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : chunk_rr_arbiter
// Description : Round-robin arbiter that grants one requester stream at a
//               time for a chunk of at most Q beats (Q taken from the cfg
//               stream, Q=0 = unlimited). A chunk ends on the requester's own
//               end-of-transaction or when the quantum is used up; the
//               rotation pointer then moves past the served requester.
// Revision    : 1.0 - initial release
// ============================================================================
module chunk_rr_arbiter #(
  parameter int NUM   = 4,
  parameter int DIN_W = 17,
  parameter int CFG_W = 8
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din [NUM],
  dti.consumer cfg,
  dti.producer dout
);

  localparam int                  c_sel_w = $clog2(NUM);
  localparam int                  c_pay_w = DIN_W - 1;
  localparam logic [c_sel_w:0]    c_num   = (c_sel_w+1)'(NUM);
  localparam logic [c_sel_w-1:0]  c_last  = c_sel_w'(NUM - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_sel_w-1:0]   r_sel;
  logic [c_sel_w-1:0]   r_ptr;
  logic [CFG_W-1:0]     r_cnt;
  logic [CFG_W-1:0]     r_q;

  logic [NUM-1:0]       w_req;
  logic [NUM-1:0]       w_eot_in;
  logic [c_pay_w-1:0]   w_pay [NUM];
  logic [NUM-1:0]       w_rdy;
  logic [CFG_W-1:0]     w_cfg_q;
  logic [c_sel_w-1:0]   w_winner;
  logic [c_sel_w:0]     w_idx;
  logic                 w_qend;
  logic                 w_chunk_end;
  logic                 w_out_vld;
  logic                 w_cfg_rdy;
  logic                 w_start;
  logic                 w_hs;
  logic                 w_end;

  // Flatten the requester interface array into plain vectors
  for (genvar gi = 0; gi < NUM; gi++) begin : g_din
    assign w_req[gi]     = din[gi].valid;
    assign w_eot_in[gi]  = din[gi].data[DIN_W-1];
    assign w_pay[gi]     = din[gi].data[c_pay_w-1:0];
    assign din[gi].ready = w_rdy[gi];
  end

  assign w_cfg_q     = cfg.data;
  // Quantum exhausted on the beat that brings the count to q
  assign w_qend      = (r_q != '0) && (r_cnt == (r_q - CFG_W'(1)));
  assign w_chunk_end = w_eot_in[r_sel] | w_qend;
  assign w_hs        = w_out_vld & dout.ready;

  assign dout.valid  = w_out_vld;
  assign dout.data   = {r_sel, w_eot_in[r_sel], w_chunk_end, w_pay[r_sel]};
  assign cfg.ready   = w_cfg_rdy;

  // Rotating priority scan: lowest distance from ptr wins (scan high to low)
  always_comb begin
    w_winner = '0;
    w_idx    = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (c_sel_w+1)'(k);
      if (w_idx >= c_num) w_idx = w_idx - c_num;
      if (w_req[w_idx[c_sel_w-1:0]]) w_winner = w_idx[c_sel_w-1:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and handshake outputs; everything is held off while in reset
  always_comb begin
    w_state_nxt = r_state;
    w_out_vld   = 1'b0;
    w_cfg_rdy   = 1'b0;
    w_rdy       = '0;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst && cfg.valid && (|w_req)) begin
          w_cfg_rdy   = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rst) begin
          w_out_vld    = w_req[r_sel];
          w_rdy[r_sel] = dout.ready;
          if (w_out_vld && dout.ready && w_chunk_end) begin
            w_end       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant index, quantum capture, beat counter and rotation pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_q   <= '0;
    end else if (w_start) begin
      r_sel <= w_winner;
      r_q   <= w_cfg_q;
      r_cnt <= '0;
    end else if (w_hs) begin
      if (w_end) begin
        r_cnt <= '0;
        r_ptr <= (r_sel == c_last) ? '0 : r_sel + 1'b1;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunk_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunk_rr_arbiter
// Description : Directed and randomised self-checking bench for
//               chunk_rr_arbiter (NUM=4, DIN_W=17, CFG_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunk_rr_arbiter;

  localparam int NUM   = 4;
  localparam int DIN_W = 17;
  localparam int CFG_W = 8;
  localparam int SW    = 2;
  localparam int PW    = DIN_W - 1;
  localparam int OW    = SW + 1 + DIN_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dti #(.W(DIN_W)) din_if [NUM] ();
  dti #(.W(CFG_W)) cfg_if ();
  dti #(.W(OW))    dout_if ();

  logic [NUM-1:0]   tb_vld;
  logic [DIN_W-1:0] tb_dat [NUM];
  logic [NUM-1:0]   tb_rdy;
  logic             cfg_v;
  logic [CFG_W-1:0] cfg_d;
  logic             cfg_r;
  logic             out_rdy;

  for (genvar gi = 0; gi < NUM; gi++) begin : g_drv
    assign din_if[gi].valid = tb_vld[gi];
    assign din_if[gi].data  = tb_dat[gi];
    assign tb_rdy[gi]       = din_if[gi].ready;
  end
  assign cfg_if.valid  = cfg_v;
  assign cfg_if.data   = cfg_d;
  assign cfg_r         = cfg_if.ready;
  assign dout_if.ready = out_rdy;

  chunk_rr_arbiter #(.NUM(NUM), .DIN_W(DIN_W), .CFG_W(CFG_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .cfg  (cfg_if),
    .dout (dout_if)
  );

  typedef struct {
    int          cyc;
    logic [OW-1:0] d;
  } beat_t;

  logic [DIN_W-1:0] srcq [NUM][$];
  logic [DIN_W-1:0] expq [NUM][$];
  beat_t            blog[$];
  int               cyc, n_cfg, n_checks, n_errors, n_ends, mcnt;
  logic [CFG_W-1:0] cur_q;
  logic [NUM-1:0]   gap_en;
  bit               rnd_rdy, rnd_cfg, chk_rand;
  logic             last_dvld, last_cfgr;
  logic [NUM-1:0]   last_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk(input logic [SW-1:0] s, input logic [1:0] e,
                                       input logic [PW-1:0] p);
    return {s, e, p};
  endfunction

  function automatic logic [DIN_W-1:0] src(input logic e, input logic [PW-1:0] p);
    return {e, p};
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM; i++) n += srcq[i].size() + expq[i].size();
    return n;
  endfunction

  // Reference model for the randomised run: order, eot flags, chunk ends
  task automatic on_beat(input logic [OW-1:0] d);
    logic [SW-1:0]    s;
    logic [1:0]       e;
    logic [DIN_W-1:0] x;
    logic             e0;
    s = d[OW-1 -: SW];
    e = d[PW+1:PW];
    if (expq[s].size() == 0) begin
      check("rand_extra_beat", 64'(s), 64'hFF);
    end else begin
      x  = expq[s].pop_front();
      e0 = x[DIN_W-1] || ((cur_q != 0) && (mcnt == int'(cur_q) - 1));
      check("rand_pay", 64'(d[PW-1:0]), 64'(x[PW-1:0]));
      check("rand_eot", 64'(e), 64'({x[DIN_W-1], e0}));
      if (e0) begin
        n_ends++;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < NUM; i++) begin
      tb_vld[i] = (srcq[i].size() > 0) && !(gap_en[i] && ($urandom_range(0, 3) == 0));
      tb_dat[i] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rnd_cfg) begin
      cfg_d = CFG_W'($urandom_range(0, 5));
      cfg_v = ($urandom_range(0, 3) != 0);
    end
    #1;
    last_dvld = dout_if.valid;
    last_rdy  = tb_rdy;
    last_cfgr = cfg_r;
    if (dout_if.valid && out_rdy) begin
      blog.push_back('{cyc, dout_if.data});
      if (chk_rand) on_beat(dout_if.data);
    end
    for (int i = 0; i < NUM; i++)
      if (tb_vld[i] && tb_rdy[i]) void'(srcq[i].pop_front());
    if (cfg_v && cfg_r) begin
      n_cfg++;
      cur_q = cfg_d;
      mcnt  = 0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    cfg_v   = 1'b0;
    rnd_rdy = 0;
    rnd_cfg = 0;
    gap_en  = '0;
    for (int i = 0; i < NUM; i++) begin
      srcq[i].delete();
      expq[i].delete();
    end
    run(2);
    blog.delete();
    n_cfg = 0;
    cyc   = 0;
  endtask

  task automatic exp_beat(input string tag, input int idx, input int ecyc,
                          input logic [OW-1:0] ed);
    if (idx < blog.size()) begin
      check($sformatf("%s%0d_data", tag, idx), 64'(blog[idx].d), 64'(ed));
      check($sformatf("%s%0d_cyc", tag, idx), 64'(blog[idx].cyc), 64'(ecyc));
    end else begin
      check($sformatf("%s%0d_missing", tag, idx), 64'(blog.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; chk_rand = 0; cur_q = '0; mcnt = 0; n_ends = 0;
    tb_vld = '0; out_rdy = 1'b1; cfg_d = '0;
    for (int i = 0; i < NUM; i++) tb_dat[i] = '0;
    @(negedge clk);

    // Reset behaviour and plain round robin over single-beat transactions
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd3;
    for (int i = 0; i < NUM; i++) srcq[i].push_back(src(1'b1, 16'h5000 + 16'(i)));
    cycle();
    check("rst_dvalid", 64'(last_dvld), 64'd0);
    check("rst_ready", 64'(last_rdy), 64'd0);
    check("rst_cfgready", 64'(last_cfgr), 64'd0);
    rst = 1'b1;
    cycle();
    check("post_rst_dvalid", 64'(last_dvld), 64'd0);
    check("post_rst_ready", 64'(last_rdy), 64'd0);
    run(8);
    for (int i = 0; i < NUM; i++)
      exp_beat("rr", i, 2 + 2 * i, mk(SW'(i), 2'b11, 16'h5000 + 16'(i)));

    // Q=3, five-beat transaction split 3+2; cfg.data changes mid-chunk are ignored
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd3;
    for (int k = 0; k < 5; k++) srcq[0].push_back(src(k == 4, 16'hA000 + 16'(k)));
    rst = 1'b1;
    cycle();
    cfg_d = 8'd1;
    run(3);
    cfg_d = 8'd3;
    run(5);
    check("q3_nbeats", 64'(blog.size()), 64'd5);
    exp_beat("q3_", 0, 1, mk(2'd0, 2'b00, 16'hA000));
    exp_beat("q3_", 1, 2, mk(2'd0, 2'b00, 16'hA001));
    exp_beat("q3_", 2, 3, mk(2'd0, 2'b01, 16'hA002));
    exp_beat("q3_", 3, 5, mk(2'd0, 2'b00, 16'hA003));
    exp_beat("q3_", 4, 6, mk(2'd0, 2'b11, 16'hA004));
    check("q3_cfg_hs", 64'(n_cfg), 64'd2);

    // Q=2, din0 and din2 interleave in chunks of two
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd2;
    for (int k = 0; k < 4; k++) begin
      srcq[0].push_back(src(k == 3, 16'hB000 + 16'(k)));
      srcq[2].push_back(src(k == 3, 16'hC000 + 16'(k)));
    end
    rst = 1'b1;
    run(13);
    check("q2_nbeats", 64'(blog.size()), 64'd8);
    exp_beat("q2_", 0, 1,  mk(2'd0, 2'b00, 16'hB000));
    exp_beat("q2_", 1, 2,  mk(2'd0, 2'b01, 16'hB001));
    exp_beat("q2_", 2, 4,  mk(2'd2, 2'b00, 16'hC000));
    exp_beat("q2_", 3, 5,  mk(2'd2, 2'b01, 16'hC001));
    exp_beat("q2_", 4, 7,  mk(2'd0, 2'b00, 16'hB002));
    exp_beat("q2_", 5, 8,  mk(2'd0, 2'b11, 16'hB003));
    exp_beat("q2_", 6, 10, mk(2'd2, 2'b00, 16'hC002));
    exp_beat("q2_", 7, 11, mk(2'd2, 2'b11, 16'hC003));
    check("q2_cfg_hs", 64'(n_cfg), 64'd4);

    // Q=0: din1 streams all 8 beats contiguously before din3 is served
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd0;
    for (int k = 0; k < 8; k++) srcq[1].push_back(src(k == 7, 16'hD000 + 16'(k)));
    srcq[3].push_back(src(1'b0, 16'hE000));
    srcq[3].push_back(src(1'b1, 16'hE001));
    rst = 1'b1;
    run(13);
    check("q0_nbeats", 64'(blog.size()), 64'd10);
    for (int k = 0; k < 8; k++)
      exp_beat("q0_", k, 1 + k, mk(2'd1, (k == 7) ? 2'b11 : 2'b00, 16'hD000 + 16'(k)));
    exp_beat("q0_", 8, 10, mk(2'd3, 2'b00, 16'hE000));
    exp_beat("q0_", 9, 11, mk(2'd3, 2'b11, 16'hE001));

    // Q=4: input eot ends the chunk early and moves the pointer to 1
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd4;
    srcq[0].push_back(src(1'b0, 16'hF000));
    srcq[0].push_back(src(1'b1, 16'hF001));
    rst = 1'b1;
    run(4);
    srcq[0].push_back(src(1'b1, 16'h6000));
    srcq[1].push_back(src(1'b1, 16'h6100));
    run(5);
    check("q4_nbeats", 64'(blog.size()), 64'd4);
    exp_beat("q4_", 0, 1, mk(2'd0, 2'b00, 16'hF000));
    exp_beat("q4_", 1, 2, mk(2'd0, 2'b11, 16'hF001));
    exp_beat("q4_", 2, 5, mk(2'd1, 2'b11, 16'h6100));
    exp_beat("q4_", 3, 7, mk(2'd0, 2'b11, 16'h6000));

    // Reset in the middle of a Q=4 chunk: chunk dropped, pointer back to 0
    do_reset();
    cfg_v = 1'b1; cfg_d = 8'd4;
    srcq[0].push_back(src(1'b1, 16'h7000));
    for (int k = 0; k < 6; k++) begin
      srcq[0].push_back(src(k == 5, 16'h7100 + 16'(k)));
      srcq[1].push_back(src(k == 5, 16'h7200 + 16'(k)));
    end
    rst = 1'b1;
    run(4);
    rst = 1'b0;
    cycle();
    check("mid_rst_dvalid", 64'(last_dvld), 64'd0);
    check("mid_rst_ready", 64'(last_rdy), 64'd0);
    rst = 1'b1;
    cycle();
    check("after_rst_dvalid", 64'(last_dvld), 64'd0);
    cycle();
    check("rst_nbeats", 64'(blog.size()), 64'd3);
    exp_beat("rst_", 0, 1, mk(2'd0, 2'b11, 16'h7000));
    exp_beat("rst_", 1, 3, mk(2'd1, 2'b00, 16'h7200));
    exp_beat("rst_", 2, 6, mk(2'd0, 2'b00, 16'h7100));

    // Randomised ready, valid gaps and quantum 0..5
    do_reset();
    n_ends = 0; mcnt = 0;
    for (int r = 0; r < NUM; r++) begin
      int seq = 0;
      for (int t = 0; t < 3; t++) begin
        int len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) begin
          srcq[r].push_back(src(b == len - 1, {4'(r), 12'(seq)}));
          expq[r].push_back(src(b == len - 1, {4'(r), 12'(seq)}));
          seq++;
        end
      end
    end
    gap_en = '1; rnd_rdy = 1; rnd_cfg = 1; chk_rand = 1;
    rst = 1'b1;
    for (int c = 0; c < 4000 && pending() > 0; c++) cycle();
    chk_rand = 0;
    check("rand_drained", 64'(pending()), 64'd0);
    check("rand_cfg_per_chunk", 64'(n_cfg), 64'(n_ends));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
